// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//
// Purpose: bundles the control bus between the multi-cycle RV32I control FSM
// and its shared-ALU / shared-memory datapath.
//
// Signals:
//   op          opcode field of the instruction register (datapath -> ctrl)
//   mem_ready   memory completes the current access this cycle
//   pc_write    PC register load enable
//   ir_write    instruction register + old-PC register load enable
//   adr_src     memory address select: 0=PC, 1=ALUOut
//   mem_write   data memory write request
//   reg_write   register file write enable
//   branch      conditional PC load when the ALU compare is true
//   alu_src_a   00=PC, 01=old PC, 10=rs1, 11=zero
//   alu_src_b   00=rs2, 01=imm, 10=constant 4
//   result_src  00=ALUOut, 01=read data, 10=ALU result
//   imm_src     001=I, 011=S, 100=B, 010=U, 101=J
//   alu_op      000=add, 001=R decode, 010=I decode, 011=branch compare
//   instr_done  one-cycle pulse on the last state of each instruction
//   illegal_op  sticky illegal-opcode flag
//
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int OP_WIDTH   = 7,
  parameter int RS_WIDTH   = 2,
  parameter int CTRL_WIDTH = 3
);
  logic [OP_WIDTH-1:0]   op;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  ir_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  reg_write;
  logic                  branch;
  logic [RS_WIDTH-1:0]   alu_src_a;
  logic [RS_WIDTH-1:0]   alu_src_b;
  logic [RS_WIDTH-1:0]   result_src;
  logic [CTRL_WIDTH-1:0] imm_src;
  logic [CTRL_WIDTH-1:0] alu_op;
  logic                  instr_done;
  logic                  illegal_op;

  modport master (
    input  op, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write, branch,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write, branch,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: Moore control FSM sequencing a multi-cycle RV32I datapath that
// shares one ALU and one memory. Every cycle it drives the enables and mux
// selects for PC, IR, register file, ALU and memory.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (state -> FETCH, illegal_op clears)
//   bus   multicycle_controller_if.master: op/mem_ready in, controls out
//
// Configuration macro:
//   ILLEGAL_OP_TRAP_EN  defined   -> unknown opcodes park the FSM in HALT and
//                                    raise illegal_op until reset
//                       undefined -> unknown opcodes retire as a NOP from
//                                    DECODE; illegal_op is constant 0
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int OP_WIDTH   = 7,
  parameter int RS_WIDTH   = 2,
  parameter int CTRL_WIDTH = 3
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_WIDTH-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_WIDTH-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_WIDTH-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_TGT,
    S_JALR_LINK, S_UPPER
`ifdef ILLEGAL_OP_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t state_q, state_d;

  logic                  pcWrite, irWrite, adrSrc, memWrite, regWrite, branchEn;
  logic                  instrDone;
  logic [RS_WIDTH-1:0]   aluSrcA, aluSrcB, resultSrc;
  logic [CTRL_WIDTH-1:0] immSrc, aluOp;

  // State register: reset is synchronous, so a mid-instruction reset only
  // takes effect on the next edge; the outputs are gated separately below.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore outputs. Only FETCH, MEMREAD and MEMWRITE look at
  // mem_ready; op is only consulted where the IR is guaranteed stable.
  // During reset the side-effecting enables are forced low so a half-done
  // store cannot write memory in the reset cycle.
  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    branchEn  = 1'b0;
    instrDone = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    aluOp     = 3'b000;
    case (state_q)
      S_FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        if (bus.mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute PC+imm into ALUOut for branches and JAL.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_TGT;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef ILLEGAL_OP_TRAP_EN
          default:           state_d = S_HALT;
`else
          default: begin
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
`endif
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write request stays up through the cycle memory accepts it.
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (bus.mem_ready) begin
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        aluSrcA = 2'b10;
        aluOp   = 3'b001;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 3'b010;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA   = 2'b10;
        aluOp     = 3'b011;
        branchEn  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL, S_JALR_LINK: begin
        // Load PC from ALUOut while the ALU forms old PC + 4 for the link.
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR_TGT: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = S_JALR_LINK;
      end
      S_UPPER: begin
        aluSrcA = (bus.op == OP_LUI) ? 2'b11 : 2'b01;
        aluSrcB = 2'b01;
        state_d = S_ALUWB;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      branchEn  = 1'b0;
      instrDone = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state so the immediate
  // generator is ready whenever the ALU wants it.
  always_comb begin
    immSrc = 3'b000;
    case (bus.op)
      OP_LOAD, OP_ITYPE, OP_JALR: immSrc = 3'b001;
      OP_STORE:                   immSrc = 3'b011;
      OP_BRANCH:                  immSrc = 3'b100;
      OP_LUI, OP_AUIPC:           immSrc = 3'b010;
      OP_JAL:                     immSrc = 3'b101;
      default:                    immSrc = 3'b000;
    endcase
  end

  assign bus.pc_write   = pcWrite;
  assign bus.ir_write   = irWrite;
  assign bus.adr_src    = adrSrc;
  assign bus.mem_write  = memWrite;
  assign bus.reg_write  = regWrite;
  assign bus.branch     = branchEn;
  assign bus.alu_src_a  = aluSrcA;
  assign bus.alu_src_b  = aluSrcB;
  assign bus.result_src = resultSrc;
  assign bus.imm_src    = immSrc;
  assign bus.alu_op     = aluOp;
  assign bus.instr_done = instrDone;

  // HALT is only left through reset, so tying the flag to the state makes it
  // sticky and clears it on the reset edge.
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op = (state_q == S_HALT);
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Purpose: self-checking bench for multicycle_controller. Each vector is one
// clock cycle: the inputs to drive plus the full control word expected in
// that cycle. Expected words come from per-state constant tables below.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic clk;
  logic rst;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       regWrite;
    logic       branch;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [2:0] immSrc;
    logic [2:0] aluOp;
    logic       instrDone;
    logic       illegalOp;
  } outs_t;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic        memReady;
    outs_t       exp;
    logic [63:0] name;
  } vec_t;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTYP  = 7'b0110011;
  localparam logic [6:0] ITYP  = 7'b0010011;
  localparam logic [6:0] BRAN  = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b0000000;

  int checks = 0;
  int errors = 0;

  outs_t expQ[$];
  vec_t  vecs[$];

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken design can never stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic outs_t ob(input logic pcW, irW, adr, memW, regW, br,
                               input logic [1:0] a, b, rs,
                               input logic [2:0] imm, aop,
                               input logic done, ill);
    outs_t t;
    t.pcWrite = pcW;  t.irWrite = irW;  t.adrSrc = adr;
    t.memWrite = memW; t.regWrite = regW; t.branch = br;
    t.aluSrcA = a;    t.aluSrcB = b;    t.resultSrc = rs;
    t.immSrc = imm;   t.aluOp = aop;    t.instrDone = done;
    t.illegalOp = ill;
    return t;
  endfunction

  // Expected control word for each FSM state.
  function automatic outs_t fFetch(input logic rdy, input logic [2:0] imm);
    return ob(rdy, rdy, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, imm, 3'b000, 0, 0);
  endfunction
  function automatic outs_t fDecode(input logic [2:0] imm, input logic done);
    return ob(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, done, 0);
  endfunction
  function automatic outs_t fMemAdr(input logic [2:0] imm);
    return ob(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic outs_t fMemRead();
    return ob(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0, 0);
  endfunction
  function automatic outs_t fMemWb();
    return ob(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b001, 3'b000, 1, 0);
  endfunction
  function automatic outs_t fMemWrite(input logic rdy);
    return ob(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, rdy, 0);
  endfunction
  function automatic outs_t fExecR();
    return ob(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0);
  endfunction
  function automatic outs_t fExecI();
    return ob(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 3'b010, 0, 0);
  endfunction
  function automatic outs_t fAluWb(input logic [2:0] imm);
    return ob(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction
  function automatic outs_t fBranch();
    return ob(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 3'b100, 3'b011, 1, 0);
  endfunction
  function automatic outs_t fJal(input logic [2:0] imm);
    return ob(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic outs_t fJalrTgt();
    return ob(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 0, 0);
  endfunction
  function automatic outs_t fUpper(input logic [1:0] a);
    return ob(0, 0, 0, 0, 0, 0, a, 2'b01, 2'b00, 3'b010, 3'b000, 0, 0);
  endfunction

  function automatic vec_t mk(input logic r, input logic [6:0] o,
                              input logic rdy, input outs_t e,
                              input logic [63:0] n);
    vec_t v;
    v.rst = r; v.op = o; v.memReady = rdy; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic outs_t sampleDut();
    return ob(bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write,
              bus.reg_write, bus.branch, bus.alu_src_a, bus.alu_src_b,
              bus.result_src, bus.imm_src, bus.alu_op, bus.instr_done,
              bus.illegal_op);
  endfunction

  // Pop the oldest expected word and compare against the live outputs.
  task automatic checkOutput(input logic [63:0] name);
    outs_t exp, got;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got scoreboard empty, required an entry", name);
    end else begin
      exp = expQ.pop_front();
      got = sampleDut();
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
      end
    end
  endtask

  // Drive one cycle's inputs mid-period, record the expectation and sample
  // shortly after, well away from the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.op        = v.op;
    bus.mem_ready = v.memReady;
    expQ.push_back(v.exp);
    #1;
    checkOutput(v.name);
  endtask

  initial begin
    rst           = 1'b1;
    bus.op        = RTYP;
    bus.mem_ready = 1'b0;
    @(posedge clk);

    // Held in reset with memory ready: FETCH selects, no enables.
    applyStimulus(mk(1, RTYP, 1, fFetch(0, 3'b000), "RESET"));

    // Straight-line instructions, memory always ready (R with a fetch stall).
    vecs.push_back(mk(0, RTYP, 0, fFetch(0, 3'b000), "R_FSTL"));
    vecs.push_back(mk(0, RTYP, 1, fFetch(1, 3'b000), "R_FETCH"));
    vecs.push_back(mk(0, RTYP, 1, fDecode(3'b000, 0), "R_DEC"));
    vecs.push_back(mk(0, RTYP, 1, fExecR(), "R_EXEC"));
    vecs.push_back(mk(0, RTYP, 1, fAluWb(3'b000), "R_WB"));
    vecs.push_back(mk(0, ITYP, 1, fFetch(1, 3'b001), "I_FETCH"));
    vecs.push_back(mk(0, ITYP, 1, fDecode(3'b001, 0), "I_DEC"));
    vecs.push_back(mk(0, ITYP, 1, fExecI(), "I_EXEC"));
    vecs.push_back(mk(0, ITYP, 1, fAluWb(3'b001), "I_WB"));
    vecs.push_back(mk(0, LUI, 1, fFetch(1, 3'b010), "LUI_F"));
    vecs.push_back(mk(0, LUI, 1, fDecode(3'b010, 0), "LUI_D"));
    vecs.push_back(mk(0, LUI, 1, fUpper(2'b11), "LUI_UP"));
    vecs.push_back(mk(0, LUI, 1, fAluWb(3'b010), "LUI_WB"));
    vecs.push_back(mk(0, AUIPC, 1, fFetch(1, 3'b010), "AUI_F"));
    vecs.push_back(mk(0, AUIPC, 1, fDecode(3'b010, 0), "AUI_D"));
    vecs.push_back(mk(0, AUIPC, 1, fUpper(2'b01), "AUI_UP"));
    vecs.push_back(mk(0, AUIPC, 1, fAluWb(3'b010), "AUI_WB"));
    vecs.push_back(mk(0, BRAN, 1, fFetch(1, 3'b100), "BR_F"));
    vecs.push_back(mk(0, BRAN, 1, fDecode(3'b100, 0), "BR_D"));
    vecs.push_back(mk(0, BRAN, 1, fBranch(), "BR_EX"));
    vecs.push_back(mk(0, JAL, 1, fFetch(1, 3'b101), "JAL_F"));
    vecs.push_back(mk(0, JAL, 1, fDecode(3'b101, 0), "JAL_D"));
    vecs.push_back(mk(0, JAL, 1, fJal(3'b101), "JAL_J"));
    vecs.push_back(mk(0, JAL, 1, fAluWb(3'b101), "JAL_WB"));
    vecs.push_back(mk(0, JALR, 1, fFetch(1, 3'b001), "JALR_F"));
    vecs.push_back(mk(0, JALR, 1, fDecode(3'b001, 0), "JALR_D"));
    vecs.push_back(mk(0, JALR, 1, fJalrTgt(), "JALR_T"));
    vecs.push_back(mk(0, JALR, 1, fJal(3'b001), "JALR_L"));
    vecs.push_back(mk(0, JALR, 1, fAluWb(3'b001), "JALR_WB"));
    vecs.push_back(mk(0, LOAD, 1, fFetch(1, 3'b001), "LD_F"));
    vecs.push_back(mk(0, LOAD, 1, fDecode(3'b001, 0), "LD_D"));
    vecs.push_back(mk(0, LOAD, 1, fMemAdr(3'b001), "LD_ADR"));
    vecs.push_back(mk(0, LOAD, 1, fMemRead(), "LD_RD"));
    vecs.push_back(mk(0, LOAD, 1, fMemWb(), "LD_WB"));
    vecs.push_back(mk(0, STORE, 1, fFetch(1, 3'b011), "ST_F"));
    vecs.push_back(mk(0, STORE, 1, fDecode(3'b011, 0), "ST_D"));
    vecs.push_back(mk(0, STORE, 1, fMemAdr(3'b011), "ST_ADR"));
    vecs.push_back(mk(0, STORE, 1, fMemWrite(1), "ST_WR"));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Load with memory stalling three cycles in MEMREAD: 8 cycles total.
    applyStimulus(mk(0, LOAD, 1, fFetch(1, 3'b001), "LS_F"));
    applyStimulus(mk(0, LOAD, 1, fDecode(3'b001, 0), "LS_D"));
    applyStimulus(mk(0, LOAD, 1, fMemAdr(3'b001), "LS_ADR"));
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(0, LOAD, 0, fMemRead(), "LS_STL"));
    applyStimulus(mk(0, LOAD, 1, fMemRead(), "LS_RD"));
    applyStimulus(mk(0, LOAD, 1, fMemWb(), "LS_WB"));

    // Store with two stall cycles: mem_write held three cycles.
    applyStimulus(mk(0, STORE, 1, fFetch(1, 3'b011), "SS_F"));
    applyStimulus(mk(0, STORE, 1, fDecode(3'b011, 0), "SS_D"));
    applyStimulus(mk(0, STORE, 1, fMemAdr(3'b011), "SS_ADR"));
    applyStimulus(mk(0, STORE, 0, fMemWrite(0), "SS_STL1"));
    applyStimulus(mk(0, STORE, 0, fMemWrite(0), "SS_STL2"));
    applyStimulus(mk(0, STORE, 1, fMemWrite(1), "SS_WR"));

    // Reset during a stalled store: the write request drops immediately.
    applyStimulus(mk(0, STORE, 1, fFetch(1, 3'b011), "RS_F"));
    applyStimulus(mk(0, STORE, 1, fDecode(3'b011, 0), "RS_D"));
    applyStimulus(mk(0, STORE, 1, fMemAdr(3'b011), "RS_ADR"));
    applyStimulus(mk(0, STORE, 0, fMemWrite(0), "RS_STL"));
    applyStimulus(mk(1, STORE, 0,
                     ob(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011,
                        3'b000, 0, 0), "RS_RST"));
    applyStimulus(mk(0, STORE, 0, fFetch(0, 3'b011), "RS_AFT"));

    // Unknown opcode.
    applyStimulus(mk(0, BAD, 1, fFetch(1, 3'b000), "IL_F"));
`ifdef ILLEGAL_OP_TRAP_EN
    applyStimulus(mk(0, BAD, 1, fDecode(3'b000, 0), "IL_D"));
    for (int i = 0; i < 12; i++)
      applyStimulus(mk(0, BAD, 1,
                       ob(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
                          3'b000, 0, 1), "IL_HALT"));
    applyStimulus(mk(1, BAD, 1,
                     ob(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,
                        3'b000, 0, 1), "IL_RST"));
    applyStimulus(mk(0, RTYP, 1, fFetch(1, 3'b000), "IL_REC"));
`else
    applyStimulus(mk(0, BAD, 1, fDecode(3'b000, 1), "IL_NOP"));
    applyStimulus(mk(0, RTYP, 1, fFetch(1, 3'b000), "IL_REC"));
`endif
    applyStimulus(mk(0, RTYP, 1, fDecode(3'b000, 0), "IL_DEC2"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore control FSM that sequences a shared-ALU, shared-memory multi-cycle RV32I datapath.
- Replaces the single-cycle main decoder when the core is built multi-cycle.
- Takes the 7-bit opcode from the instruction register plus a memory ready handshake.
- Drives per-cycle enables and mux selects for PC, IR, register file, ALU and memory.

Parameters:
OP_WIDTH, 7, opcode width
RS_WIDTH, 2, width of result_src / alu_src_a / alu_src_b selects
CTRL_WIDTH, 3, width of imm_src / alu_op

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op  in  OP_WIDTH  opcode field of instruction register
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC register load enable
ir_write  out  1  instruction register + old-PC register load enable
adr_src  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  data memory write request
reg_write  out  1  register file write enable
branch  out  1  conditional PC load if ALU zero/compare true
alu_src_a  out  RS_WIDTH  00=PC, 01=old PC, 10=rs1, 11=zero
alu_src_b  out  RS_WIDTH  00=rs2, 01=imm, 10=constant 4
result_src  out  RS_WIDTH  00=ALUOut, 01=read data, 10=ALU result
imm_src  out  CTRL_WIDTH  001=I, 011=S, 100=B, 010=U, 101=J, decoded from op in all states
alu_op  out  CTRL_WIDTH  000=add, 001=R funct decode, 010=I funct decode, 011=branch compare
instr_done  out  1  one-cycle pulse on the last state of each instruction
illegal_op  out  1  sticky illegal-opcode flag; tied 0 unless feature enabled

Behaviour:
- Outputs are a pure function of state, plus mem_ready gating in FETCH / MEMREAD / MEMWRITE; no output registers.
- Unlisted outputs are 0; selects are 00 unless stated.
- While rst=1, pc_write, ir_write, mem_write, reg_write, branch and instr_done are forced to 0.
- On the clock edge with rst=1, state goes to FETCH and illegal_op clears. This also applies mid-instruction: a pending mem_write drops in the reset cycle.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=000, result_src=10.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: ir_write=0, pc_write=0, stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=000 (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_TGT
  - 0110111 / 0010111 -> UPPER
  - other -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=000. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits for mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until the mem_ready=1 cycle (inclusive). In that cycle instr_done=1, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=001, then ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=010, then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=011, result_src=00, branch=1, instr_done=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=000, result_src=00, pc_write=1, then ALUWB (writes old PC+4).
- JALR_TGT: alu_src_a=10, alu_src_b=01, alu_op=000, then JALR_LINK.
- JALR_LINK: same outputs as JAL, then ALUWB.
- UPPER: alu_src_b=01, alu_op=000; alu_src_a=11 for op 0110111, 01 for op 0010111. Then ALUWB.
- Cycle counts with mem_ready always 1:
  - load 5
  - store 4
  - R/I/U 4
  - branch 3
  - JAL 4
  - JALR 5
- op is sampled only in DECODE, MEMADR and UPPER; it is stable because ir_write=0 outside FETCH.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unlisted opcode in DECODE goes to HALT.
  - HALT: all enables 0, illegal_op=1; stays in HALT until rst.
- Undefined:
  - An unlisted opcode in DECODE goes directly to FETCH with instr_done=1 in DECODE (NOP).
  - HALT does not exist; illegal_op is constant 0.

Test Plan:
- Reset then op=0110011, mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 only in cycle 4 with result_src=00; instr_done pulses cycle 4.
- Load op=0000011, mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles with adr_src=1 throughout; MEMWB follows with result_src=01, reg_write=1; total 8 cycles.
- Store op=0100011, mem_ready=0 for 2 cycles in MEMWRITE -> mem_write=1 for exactly 3 cycles; reg_write never 1.
- JALR op=1100111 -> pc_write=1 only in JALR_LINK with alu_src_a=01, alu_src_b=10; reg_write=1 in the next cycle; 5 cycles total.
- rst=1 asserted during MEMWRITE with mem_ready=0 -> mem_write=0 in the same cycle; state is FETCH on the next edge.
- op=0000000:
  - With ILLEGAL_OP_TRAP_EN: illegal_op=1 from the cycle after DECODE, FSM stuck, no enables for 10+ cycles.
  - Without the macro: back to FETCH after 2 cycles.
